// File: rtl/regfile_sb.sv
// Register file (2 combinational reads, 1 synchronous write, x0 = 0) with a
// per-register pending-write scoreboard. Optional macro REGFILE_SB_BYPASS_EN adds write-through forwarding.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int PENDW = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we3,
  input  logic [AW-1:0]   wa3,
  input  logic [XLEN-1:0] wd3,
  input  logic            wb_rel,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_stall
);

  localparam logic [PENDW-1:0] MAXP = {PENDW{1'b1}};
  localparam logic [PENDW-1:0] ONE  = PENDW'(1);

  logic [XLEN-1:0]  rf_q   [NREGS];
  logic [XLEN-1:0]  rf_d   [NREGS];
  logic [PENDW-1:0] pend_q [NREGS];
  logic [PENDW-1:0] pend_d [NREGS];

  logic             inc_v  [NREGS];
  logic             dec_v  [NREGS];
  logic             rel_iss;
  logic             stall_c;

  // A release only counts against a register that actually has a pending entry.
  assign rel_iss = we3 && wb_rel && (wa3 == iss_rd) && (pend_q[iss_rd] != '0);
  assign stall_c = iss_valid && (iss_rd != '0) && (pend_q[iss_rd] == MAXP) && !rel_iss;
  assign iss_stall = stall_c;

  always_comb begin
    rf_d   = rf_q;
    pend_d = pend_q;
    for (int r = 0; r < NREGS; r++) begin
      inc_v[r] = 1'b0;
      dec_v[r] = 1'b0;
    end
    if (we3 && (wa3 != '0)) begin
      rf_d[wa3] = wd3;
    end
    for (int r = 1; r < NREGS; r++) begin
      inc_v[r] = iss_valid && !stall_c && (iss_rd == AW'(r));
      dec_v[r] = we3 && wb_rel && (wa3 == AW'(r)) && (pend_q[r] != '0);
      if (inc_v[r] && !dec_v[r]) begin
        pend_d[r] = pend_q[r] + ONE;
      end else if (dec_v[r] && !inc_v[r]) begin
        pend_d[r] = pend_q[r] - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_q   <= '{default: '0};
      pend_q <= '{default: '0};
    end else begin
      rf_q   <= rf_d;
      pend_q <= pend_d;
    end
  end

`ifdef REGFILE_SB_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1 = we3 && (wa3 != '0) && (wa3 == ra1);
  assign fwd2 = we3 && (wa3 != '0) && (wa3 == ra2);

  always_comb begin
    rd1 = (ra1 == '0) ? '0 : (fwd1 ? wd3 : rf_q[ra1]);
    rd2 = (ra2 == '0) ? '0 : (fwd2 ? wd3 : rf_q[ra2]);
    // The last outstanding result arriving now clears the hazard this cycle.
    busy1 = (ra1 != '0) && (pend_q[ra1] != '0) && !(fwd1 && wb_rel && (pend_q[ra1] == ONE));
    busy2 = (ra2 != '0) && (pend_q[ra2] != '0) && !(fwd2 && wb_rel && (pend_q[ra2] == ONE));
  end
`else
  always_comb begin
    rd1   = (ra1 == '0) ? '0 : rf_q[ra1];
    rd2   = (ra2 == '0) ? '0 : rf_q[ra2];
    busy1 = (ra1 != '0) && (pend_q[ra1] != '0);
    busy2 = (ra2 != '0) && (pend_q[ra2] != '0);
  end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised + directed bench for regfile_sb against an array-based model.
module tb_regfile_sb;
  logic        clk;
  logic        reset_n;
  logic [4:0]  ra1, ra2, wa3, iss_rd;
  logic [31:0] rd1, rd2, wd3;
  logic        busy1, busy2, we3, wb_rel, iss_valid, iss_stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_rf   [32];
  int          mdl_pend [32];

  regfile_sb dut (
    .clk(clk), .reset_n(reset_n),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .wb_rel(wb_rel),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void mdl_clear();
    for (int i = 0; i < 32; i++) begin
      mdl_rf[i]   = '0;
      mdl_pend[i] = 0;
    end
  endfunction

  function automatic bit exp_stall();
    bit rel;
    if (!iss_valid || iss_rd == 0) return 1'b0;
    rel = we3 && wb_rel && wa3 == iss_rd && mdl_pend[iss_rd] != 0;
    return mdl_pend[iss_rd] == 3 && !rel;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    if (we3 && wa3 == ra) return wd3;
`endif
    return mdl_rf[ra];
  endfunction

  function automatic bit exp_busy(input logic [4:0] ra);
    if (ra == 0 || mdl_pend[ra] == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    if (we3 && wb_rel && wa3 == ra && mdl_pend[ra] == 1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic void mdl_tick();
    bit st, inc, dec;
    st = exp_stall();
    for (int r = 1; r < 32; r++) begin
      inc = iss_valid && iss_rd == r && !st;
      dec = we3 && wb_rel && wa3 == r && mdl_pend[r] != 0;
      if (inc && !dec) mdl_pend[r]++;
      else if (dec && !inc) mdl_pend[r]--;
    end
    if (we3 && wa3 != 0) mdl_rf[wa3] = wd3;
  endfunction

  task automatic idle();
    we3 = 0; wb_rel = 0; wa3 = 0; wd3 = 0; iss_valid = 0; iss_rd = 0;
  endtask

  // Check outputs against the model for the currently driven inputs, then clock.
  task automatic cycle();
    #2;
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("busy1", 32'(busy1), 32'(exp_busy(ra1)));
    chk("busy2", 32'(busy2), 32'(exp_busy(ra2)));
    chk("iss_stall", 32'(iss_stall), 32'(exp_stall()));
    @(posedge clk);
    mdl_tick();
    #1;
  endtask

  task automatic issue(input logic [4:0] r);
    idle(); iss_valid = 1; iss_rd = r; cycle();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic rel);
    idle(); we3 = 1; wa3 = a; wd3 = d; wb_rel = rel; cycle();
  endtask

  initial begin
    reset_n = 0; ra1 = 0; ra2 = 0; idle(); mdl_clear();
    #12;
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_busy1", 32'(busy1), 32'h0);
    chk("rst_stall", 32'(iss_stall), 32'h0);
    reset_n = 1;
    @(posedge clk); #1;

    // Mid-cycle async reset clears data and scoreboard without a clock edge
    ra1 = 5; ra2 = 5;
    wr(5, 32'hDEADBEEF, 0);
    issue(5);
    idle(); cycle();
    chk("pre_rst_rd1", rd1, 32'hDEADBEEF);
    #1 reset_n = 0;
    #1;
    chk("async_rst_rd1", rd1, 32'h0);
    chk("async_rst_busy1", 32'(busy1), 32'h0);
    chk("async_rst_stall", 32'(iss_stall), 32'h0);
    mdl_clear();
    #1 reset_n = 1;

    // x0
    ra1 = 0; ra2 = 0;
    idle(); we3 = 1; wa3 = 0; wd3 = 32'hFFFFFFFF; iss_valid = 1; iss_rd = 0;
    cycle();
    idle(); cycle();
    chk("x0_rd1", rd1, 32'h0);

    // Saturation on x7
    ra1 = 7;
    issue(7); issue(7); issue(7);
    chk("sat_busy", 32'(busy1), 32'h1);
    idle(); iss_valid = 1; iss_rd = 7;
    #2 chk("sat_stall", 32'(iss_stall), 32'h1);
    cycle();
    idle(); iss_valid = 1; iss_rd = 7; we3 = 1; wb_rel = 1; wa3 = 7; wd3 = 32'h77;
    #2 chk("sat_rel_stall", 32'(iss_stall), 32'h0);
    cycle();
    idle(); iss_valid = 1; iss_rd = 7;
    #2 chk("sat_still3", 32'(iss_stall), 32'h1);
    cycle();

    // Release on x9
    ra1 = 9;
    issue(9); issue(9);
    wr(9, 32'h11, 1);
    idle(); cycle();
    chk("rel1_busy", 32'(busy1), 32'h1);
    wr(9, 32'h22, 1);
    idle(); cycle();
    chk("rel2_busy", 32'(busy1), 32'h0);
    chk("rel2_data", rd1, 32'h22);
    wr(9, 32'h33, 1);
    idle(); cycle();
    chk("extra_busy", 32'(busy1), 32'h0);
    chk("extra_data", rd1, 32'h33);
    issue(9);
    chk("extra_no_underflow", 32'(busy1), 32'h1);

    // Bypass / non-bypass on x3
    ra2 = 3;
    wr(3, 32'hAAAA, 0);
    issue(3);
    idle(); we3 = 1; wb_rel = 1; wa3 = 3; wd3 = 32'h1234;
    #2;
`ifdef REGFILE_SB_BYPASS_EN
    chk("byp_rd2", rd2, 32'h1234);
    chk("byp_busy2", 32'(busy2), 32'h0);
`else
    chk("nobyp_rd2", rd2, 32'hAAAA);
    chk("nobyp_busy2", 32'(busy2), 32'h1);
`endif
    cycle();
    idle(); cycle();
    chk("after_wb_rd2", rd2, 32'h1234);
    chk("after_wb_busy2", 32'(busy2), 32'h0);

    // Plain write to a pending register leaves it busy
    ra1 = 4;
    issue(4);
    wr(4, 32'h4444, 0);
    idle(); cycle();
    chk("plain_data", rd1, 32'h4444);
    chk("plain_busy", 32'(busy1), 32'h1);

    // Random traffic over a narrow register window to force collisions
    for (int n = 0; n < 3000; n++) begin
      ra1       = 5'($urandom_range(0, 7));
      ra2       = 5'($urandom_range(0, 7));
      we3       = 1'($urandom_range(0, 1));
      wb_rel    = 1'($urandom_range(0, 1));
      wa3       = 5'($urandom_range(0, 7));
      wd3       = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle register file, for the pipelined core.
- Provides 2 combinational read ports and 1 synchronous write port. x0 is hardwired to zero.
- Adds asynchronous clear of all registers.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards against long-latency ops (loads, multi-cycle ALU).
- Sits between decode (issue/read) and writeback.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; power of 2, ≥2; AW = log2(NREGS)
PENDW, 2, width of each per-register pending counter; MAXP = 2^PENDW - 1 in-flight writes per register

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
ra1  input  AW  read address port 1
ra2  input  AW  read address port 2
rd1  output  XLEN  read data port 1
rd2  output  XLEN  read data port 2
busy1  output  1  ra1 has ≥1 pending write not yet released
busy2  output  1  ra2 has ≥1 pending write not yet released
we3  input  1  write enable
wa3  input  AW  write address
wd3  input  XLEN  write data
wb_rel  input  1  this write retires one scoreboard entry of wa3; ignored unless we3=1
iss_valid  input  1  decode issues an op that will later write iss_rd with wb_rel
iss_rd  input  AW  destination of issued op
iss_stall  output  1  issue refused this cycle (counter saturated)

Behaviour:
- Reset (reset_n=0, async):
  - All registers cleared to 0 and all pending counters cleared to 0, immediately, independent of clk.
  - Outputs while in reset: rd1=rd2=0, busy1=busy2=0, iss_stall=0.
  - All inputs are ignored until the first rising edge after reset_n returns to 1.
- Reads: combinational, zero latency. A read of address 0 returns 0 regardless of writes or bypass.
- Write: on the rising edge with we3=1 and wa3≠0, rf[wa3] <= wd3. Writes to x0 are discarded.
- Scoreboard (per register r≠0, pend[r] is PENDW bits):
  - inc = iss_valid && iss_rd==r && !iss_stall
  - dec = we3 && wb_rel && wa3==r && pend[r]≠0
  - Update on the clock edge:
    - inc only: pend+1
    - dec only: pend-1
    - inc and dec in the same cycle: unchanged (net 0)
  - wb_rel against a register with pend=0 is a protocol error: the counter stays 0 (no underflow); the data write still occurs.
  - iss_rd=0 never increments and never stalls.
- iss_stall = iss_valid && iss_rd≠0 && pend[iss_rd]==MAXP && !(same-cycle dec of iss_rd). A same-cycle release frees a slot, so issue proceeds.
- busy1 = ra1≠0 && pend[ra1]≠0. busy2 is defined the same way for ra2.
- busy is computed from the registered counters; a same-cycle issue to ra does not raise busy until the next cycle.
- A write without wb_rel (e.g. single-cycle ALU result) updates data only and never touches pend.

Optional Feature:
Macro REGFILE_SB_BYPASS_EN.
- Defined:
  - Write-through forwarding: if we3 && wa3≠0 && wa3==raN, rdN = wd3 in the same cycle.
  - busyN is also suppressed when that write carries wb_rel and pend[raN]==1, since the final pending value is being delivered now.
- Undefined:
  - rdN shows the pre-edge register contents; the new value becomes visible the cycle after the write.
  - busyN reflects only the registered counter.
  - The pipeline must then stall one extra cycle.

Test Plan:
- Reset: write 0xDEADBEEF to x5, wait 1 cycle, pulse reset_n low mid-cycle → rd1 (ra1=5) reads 0 before the next clk edge; busy1=0.
- x0 handling: we3=1, wa3=0, wd3=0xFFFFFFFF; also issue iss_rd=0 → rd1(ra1=0)=0, busy1=0, iss_stall=0.
- Saturation:
  - Issue x7 three times (PENDW=2) → busy1(ra1=7)=1.
  - Fourth issue → iss_stall=1 and pend stays 3.
  - Same fourth issue with a simultaneous we3+wb_rel to x7 → iss_stall=0, pend stays 3.
- Release:
  - Issue x9 twice, then two writebacks wb_rel=1 with wd3=0x11, then 0x22.
  - busy stays 1 after the first writeback and drops after the second; rd reads 0x22.
  - Extra wb_rel write to x9 with 0x33 → pend stays 0, data becomes 0x33.
- Bypass: pend[x3]=1, same cycle we3=1, wb_rel=1, wa3=3, wd3=0x1234, ra2=3.
  - With REGFILE_SB_BYPASS_EN: rd2=0x1234, busy2=0.
  - Without it: rd2=old value, busy2=1; next cycle rd2=0x1234, busy2=0.
- Plain write: we3=1, wb_rel=0 to x4 while pend[x4]=1 → data updates, busy(x4) stays 1.
